// File: rtl/node_control.sv
// node_control: instruction sequencer for one compute node.
// Holds a small program memory, fetches and decodes 18-bit instructions, and
// drives the datapath control strobes. It also handshakes words on four input
// ports and four output ports.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   run                    1 = execute, 0 = halt at the next instruction boundary
//   prog_we/addr/data      program-memory write port (honoured only while idle)
//   prog_last              last program address; pc wraps to 0 after it
//   ACCond                 accumulator value from the datapath (two's complement)
//   in_valid/in_ready      per-input-port handshake
//   out_valid/out_ready    per-output-port handshake
//   SwpActiveReg, SwpinA, SwpinB, enBak, ALUdesk, datainstr   datapath controls
//   pc, busy, stall        status
//
// Bit numbering: the instruction format counts bits MSB-first (bit 0 is the
// MSB). Here the vectors are declared [N-1:0], so opcode = [17:14],
// src = [13:11], dst = [10:8], imm = [7:0], and the ACC sign bit is ACCond[7].
module node_control #(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned AW         = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [17:0]   prog_data,
   input  logic [AW-1:0] prog_last,
   input  logic [7:0]    ACCond,
   input  logic [3:0]    in_valid,
   output logic [3:0]    in_ready,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic          SwpActiveReg,
   output logic [1:0]    SwpinA,
   output logic          SwpinB,
   output logic          enBak,
   output logic [1:0]    ALUdesk,
   output logic [13:0]   datainstr,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          stall
);

   typedef enum logic [1:0] {IDLE, EXEC, WAIT_IN, WAIT_OUT} state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3,
      OP_ADD = 4'd4, OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7,
      OP_JEZ = 4'd8, OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11
   } op_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [17:0]   mem [PROG_DEPTH];

   logic [17:0]   instr;
   op_t           op;
   logic [2:0]    src, dst;
   logic [7:0]    imm;
   logic          need_in, src_avail, mov_to_port, jump_taken, effect;
   logic [AW-1:0] pc_inc;

   // Program memory: no reset, and writes are accepted only while idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state_q == IDLE)) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // Decode of the instruction at pc (stable through any wait state).
   always_comb begin
      instr       = mem[pc_q];
      op          = op_t'(instr[17:14]);
      src         = instr[13:11];
      dst         = instr[10:8];
      imm         = instr[7:0];
      need_in     = ((op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB)) && !src[2];
      src_avail   = in_valid[src[1:0]];
      mov_to_port = (op == OP_MOV) && !dst[2];
      pc_inc      = (pc_q == prog_last) ? '0 : pc_q + AW'(1);
      jump_taken  = 1'b0;
      case (op)
         OP_JMP:  jump_taken = 1'b1;
         OP_JEZ:  jump_taken = (ACCond == 8'd0);
         OP_JNZ:  jump_taken = (ACCond != 8'd0);
         OP_JGZ:  jump_taken = ($signed(ACCond) > 8'sd0);
         OP_JLZ:  jump_taken = ACCond[7];
         default: jump_taken = 1'b0;
      endcase
      // Single cycle on which the instruction acts on the datapath.
      effect = ((state_q == EXEC) && run && !(need_in && !src_avail)) ||
               ((state_q == WAIT_IN) && src_avail);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next-state logic. An EXEC cycle is an instruction boundary, so run=0
   // there halts without executing; wait states always finish first.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (run) state_d = EXEC;
         end
         EXEC: begin
            if (!run) begin
               state_d = IDLE;
            end else if (need_in && !src_avail) begin
               state_d = WAIT_IN;
            end else if (mov_to_port) begin
               state_d = WAIT_OUT;
            end else begin
               pc_d = jump_taken ? imm[AW-1:0] : pc_inc;
            end
         end
         WAIT_IN: begin
            if (src_avail) begin
               if (mov_to_port) begin
                  state_d = WAIT_OUT;
               end else begin
                  pc_d    = pc_inc;
                  state_d = run ? EXEC : IDLE;
               end
            end
         end
         WAIT_OUT: begin
            if (out_ready[dst[1:0]]) begin
               pc_d    = pc_inc;
               state_d = run ? EXEC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: idle control set except on the effect cycle.
   always_comb begin
      SwpActiveReg = 1'b0;
      SwpinA       = 2'b00;
      SwpinB       = 1'b0;
      enBak        = 1'b0;
      ALUdesk      = 2'b00;
      datainstr    = {3'd0, 3'd7, 8'd0};
      in_ready     = '0;
      out_valid    = '0;
      if (effect) begin
         if (need_in) in_ready[src[1:0]] = 1'b1;
         case (op)
            OP_MOV: datainstr = {src, dst, imm};
            OP_SAV: datainstr = {3'd4, 3'd5, imm};
            OP_SWP: begin
               SwpActiveReg = 1'b1;
               SwpinA       = 2'b11;
               SwpinB       = 1'b1;
               enBak        = 1'b1;
               datainstr    = {src, 3'd7, imm};
            end
            OP_ADD, OP_SUB, OP_NEG: begin
               SwpActiveReg = 1'b1;
               SwpinA       = 2'b01;
               ALUdesk      = (op == OP_ADD) ? 2'b00 : (op == OP_SUB) ? 2'b01 : 2'b10;
               datainstr    = {src, 3'd7, imm};
            end
            default: ;
         endcase
      end
      if (state_q == WAIT_OUT) out_valid[dst[1:0]] = 1'b1;
   end

   assign pc    = pc_q;
   assign busy  = (state_q != IDLE);
   assign stall = (state_q == WAIT_IN) || (state_q == WAIT_OUT);

endmodule

// File: tb/tb_node_control.sv
// tb_node_control: directed self-checking bench for node_control.
// A small accumulator model driven by the control outputs supplies ACCond.
`timescale 1ns/1ps
module tb_node_control;

   logic        clk = 1'b0;
   logic        reset, run, prog_we;
   logic [3:0]  prog_addr, prog_last, pc;
   logic [17:0] prog_data;
   logic [7:0]  acc;
   logic [3:0]  in_valid, in_ready, out_valid, out_ready;
   logic        SwpActiveReg, SwpinB, enBak, busy, stall;
   logic [1:0]  SwpinA, ALUdesk;
   logic [13:0] datainstr;
   logic [20:0] ctl_obs;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   node_control #(.PROG_DEPTH(16), .AW(4)) dut (
      .clk(clk), .reset(reset), .run(run), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_last(prog_last),
      .ACCond(acc), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .SwpActiveReg(SwpActiveReg), .SwpinA(SwpinA), .SwpinB(SwpinB),
      .enBak(enBak), .ALUdesk(ALUdesk), .datainstr(datainstr),
      .pc(pc), .busy(busy), .stall(stall)
   );

   assign ctl_obs = {SwpActiveReg, SwpinA, SwpinB, enBak, ALUdesk, datainstr};

   // Accumulator model: MOV to ACC loads the source, ALU ops update ACC.
   logic [7:0] srcval;
   always_comb begin
      srcval = 8'd0;
      case (datainstr[13:11])
         3'd4:    srcval = acc;
         3'd5:    srcval = datainstr[7:0];
         default: srcval = 8'd0;
      endcase
   end
   always @(posedge clk) begin
      if (reset) acc <= 8'd0;
      else if (!SwpActiveReg && datainstr[10:8] == 3'd4) acc <= srcval;
      else if (SwpActiveReg && SwpinA == 2'b01) begin
         case (ALUdesk)
            2'b00:   acc <= acc + srcval;
            2'b01:   acc <= acc - srcval;
            2'b10:   acc <= 8'd0 - acc;
            default: ;
         endcase
      end
   end

   function automatic logic [17:0] ins(input logic [3:0] op, input logic [2:0] s,
                                       input logic [2:0] d, input logic [7:0] im);
      return {op, s, d, im};
   endfunction

   function automatic logic [20:0] mk(input logic sar, input logic [1:0] a, input logic b,
                                      input logic eb, input logic [1:0] alu, input logic [2:0] s,
                                      input logic [2:0] d, input logic [7:0] im);
      return {sar, a, b, eb, alu, s, d, im};
   endfunction

   localparam logic [20:0] IDLE_CTL = 21'h000700;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Direct comparison against an expected value supplied at the call site.
   task automatic exp_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, e);
      end
   endtask

   // Scoreboard comparison: pops the oldest queued expectation.
   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s: got %0h with no queued expectation", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, e);
         end
      end
   endtask

   task automatic load(input logic [3:0] a, input logic [17:0] w);
      prog_we = 1'b1; prog_addr = a; prog_data = w;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; in_valid = '0; out_ready = '0; prog_we = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      prog_addr = '0; prog_data = '0; prog_last = 4'd15;
      do_reset();
      exp_chk("rst_pc", pc, 0);
      exp_chk("rst_busy", busy, 0);
      exp_chk("rst_stall", stall, 0);
      exp_chk("rst_in_ready", in_ready, 0);
      exp_chk("rst_out_valid", out_valid, 0);
      exp_chk("rst_ctl", ctl_obs, IDLE_CTL);

      // MOV IMM->ACC 0x07, ADD IMM 0x03
      load(0, ins(1, 5, 4, 8'h07));
      load(1, ins(4, 5, 7, 8'h03));
      load(2, ins(0, 0, 0, 8'h00));
      run = 1'b1; #1;
      exp_chk("t1_idle_busy", busy, 0);
      tick();
      exp_chk("t1_pc0", pc, 0);
      exp_chk("t1_busy", busy, 1);
      exp_chk("t1_mov_ctl", ctl_obs, mk(0, 0, 0, 0, 0, 5, 4, 8'h07));
      tick();
      exp_chk("t1_acc7", acc, 8'h07);
      exp_chk("t1_add_ctl", ctl_obs, mk(1, 1, 0, 0, 0, 5, 7, 8'h03));
      tick();
      exp_chk("t1_acc0a", acc, 8'h0A);
      exp_chk("t1_pc2", pc, 2);
      run = 1'b0;
      tick();
      exp_chk("t1_halt_busy", busy, 0);
      exp_chk("t1_halt_pc", pc, 2);

      // Conditional jumps
      do_reset();
      load(0, ins(1, 5, 4, 8'hFF));
      load(1, ins(11, 7, 7, 8'h03));
      load(2, ins(0, 0, 0, 8'h00));
      load(3, ins(1, 5, 4, 8'h00));
      load(4, ins(10, 7, 7, 8'h03));
      load(5, ins(8, 7, 7, 8'h08));
      load(8, ins(0, 0, 0, 8'h00));
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(8);
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t2_pc", pc);
         if (i == 1) exp_chk("t2_jump_ctl", ctl_obs, IDLE_CTL);
      end
      run = 1'b0;
      tick();
      exp_chk("t2_halt_pc", pc, 8);

      // MOV port0 -> port1 with input stall and output stall
      do_reset();
      load(0, ins(1, 0, 1, 8'h00));
      load(1, ins(0, 0, 0, 8'h00));
      run = 1'b1;
      tick();
      exp_chk("t3_exec_ready", in_ready, 0);
      exp_chk("t3_exec_stall", stall, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         in_valid = (i >= 3) ? 4'b1110 : 4'b0000; #1;
         exp_chk("t3_win_stall", stall, 1);
         exp_chk("t3_win_ready", in_ready, 0);
         exp_chk("t3_win_ctl", ctl_obs, IDLE_CTL);
         tick();
      end
      in_valid = 4'b0001; #1;
      exp_chk("t3_consume_ready", in_ready, 4'b0001);
      exp_chk("t3_consume_ctl", ctl_obs, mk(0, 0, 0, 0, 0, 0, 1, 8'h00));
      exp_chk("t3_consume_ov", out_valid, 0);
      tick();
      in_valid = 4'b0000; #1;
      exp_chk("t3_wout_ov", out_valid, 4'b0010);
      exp_chk("t3_wout_ready", in_ready, 0);
      exp_chk("t3_wout_pc", pc, 0);
      out_ready = 4'b1101; #1;
      tick();
      exp_chk("t3_wout_hold", out_valid, 4'b0010);
      out_ready = 4'b0010; run = 1'b0; #1;
      exp_chk("t3_accept_ov", out_valid, 4'b0010);
      tick();
      out_ready = 4'b0000; #1;
      exp_chk("t3_done_pc", pc, 1);
      exp_chk("t3_done_busy", busy, 0);
      exp_chk("t3_done_ov", out_valid, 0);

      // Control sets for SAV / SWP / SUB / NEG / reserved opcode
      do_reset();
      load(0, ins(3, 0, 0, 8'h11));
      load(1, ins(2, 7, 1, 8'h22));
      load(2, ins(5, 5, 0, 8'h01));
      load(3, ins(6, 4, 0, 8'h00));
      load(4, ins(13, 5, 4, 8'h33));
      exp_q.push_back(32'(mk(0, 0, 0, 0, 0, 4, 5, 8'h11)));
      exp_q.push_back(32'(mk(1, 3, 1, 1, 0, 7, 7, 8'h22)));
      exp_q.push_back(32'(mk(1, 1, 0, 0, 1, 5, 7, 8'h01)));
      exp_q.push_back(32'(mk(1, 1, 0, 0, 2, 4, 7, 8'h00)));
      exp_q.push_back(32'(IDLE_CTL));
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_ctl", ctl_obs);
      end
      run = 1'b0;
      tick();

      // pc wrap at prog_last
      do_reset();
      load(0, ins(0, 0, 0, 8'h00));
      load(1, ins(0, 0, 0, 8'h00));
      load(2, ins(0, 0, 0, 8'h00));
      prog_last = 4'd2;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(0); exp_q.push_back(1);
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_wrap_pc", pc);
      end
      run = 1'b0;
      tick();
      prog_last = 4'd15;

      // Reset during WAIT_OUT; program writes while running are ignored
      do_reset();
      load(0, ins(1, 5, 2, 8'h55));
      load(1, ins(0, 0, 0, 8'h00));
      run = 1'b1;
      tick();
      exp_chk("t5_mov_ctl", ctl_obs, mk(0, 0, 0, 0, 0, 5, 2, 8'h55));
      tick();
      exp_chk("t5_wout_ov", out_valid, 4'b0100);
      prog_we = 1'b1; prog_addr = 4'd1; prog_data = ins(7, 7, 7, 8'h09);
      tick();
      prog_we = 1'b0; #1;
      exp_chk("t5_wout_hold", out_valid, 4'b0100);
      reset = 1'b1;
      tick();
      reset = 1'b0; run = 1'b0; #1;
      exp_chk("t5_rst_ov", out_valid, 0);
      exp_chk("t5_rst_pc", pc, 0);
      exp_chk("t5_rst_busy", busy, 0);
      exp_chk("t5_rst_stall", stall, 0);
      load(0, ins(0, 0, 0, 8'h00));
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_mem_pc", pc);
      end
      run = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/node_control.md
NODE_CONTROL -- requirements
Module: node_control

Interface
REQ-001 Parameter PROG_DEPTH, default 16: number of program slots.
REQ-002 Parameter AW, default 4: program address width, with log2(PROG_DEPTH)=AW.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  1=execute program, 0=halt at next instruction boundary.
REQ-006 prog_we / prog_addr / prog_data  in  1 / AW / 18  program-memory write port.
REQ-007 prog_last  in  AW  address of last instruction; PC wraps after it.
REQ-008 ACCond  in  8  ACC value from datapath, two's complement, bit [0] is the sign bit.
REQ-009 in_valid / in_ready  in / out  4 / 4  per input port; a word is consumed on a cycle with valid & ready.
REQ-010 out_valid / out_ready  out / in  4 / 4  per output port; a word is delivered on a cycle with valid & ready.
REQ-011 SwpActiveReg 1, SwpinA 2, SwpinB 1, enBak 1, ALUdesk 2, datainstr 14  out  datapath controls.
REQ-012 pc  out  AW  current PC; busy  out  1  state != IDLE; stall  out  1  state is WAIT_IN or WAIT_OUT.

Function
REQ-013 Instruction word: [0:3] opcode, [4:6] src, [7:9] dst, [10:17] imm; datainstr SHALL be {src,dst,imm}.
REQ-014 Src codes: 0-3 = port, 4 = ACC, 5 = IMM, 6 = BAK, 7 = NIL (0). Dst codes: 0-3 = port, 4 = ACC, 5 = BAK, 6/7 = NIL.
REQ-015 Opcodes: 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ; 12-15 execute as NOP.
REQ-016 Idle control set (IDLE, stalls, NOP, jumps): SwpActiveReg=0, SwpinA=00, SwpinB=0, enBak=0, ALUdesk=00, datainstr dst field=7.
REQ-017 MOV: SwpActiveReg=0, SwpinA=00, SwpinB=0, with src/dst as encoded.
REQ-018 SAV: SwpActiveReg=0, datainstr src forced to 4 and dst forced to 5.
REQ-019 SWP: SwpActiveReg=1, SwpinA=11, SwpinB=1, enBak=1, dst forced to 7.
REQ-020 ADD/SUB/NEG: SwpActiveReg=1, SwpinA=01, enBak=0, ALUdesk 00/01/10, dst forced to 7.
REQ-021 States: IDLE, EXEC, WAIT_IN, WAIT_OUT; non-idle controls are driven combinationally only on the single "effect" cycle of each instruction.
REQ-022 IDLE->EXEC when run=1, starting at the current pc; EXEC->IDLE at an instruction boundary when run=0.
REQ-023 An instruction whose src is port p (MOV/ADD/SUB) enters WAIT_IN unless in_valid[p]=1; the effect cycle is the first cycle with in_valid[p]=1, and in_ready[p]=1 only on that cycle.
REQ-024 A MOV to dst port p: after the effect cycle, enter WAIT_OUT with out_valid[p]=1 until out_ready[p]=1; pc advances on the accepting cycle.
REQ-025 With no stall, every instruction takes 1 cycle; pc advances on the effect cycle, or on the acceptance cycle for port writes.
REQ-026 pc advance: pc==prog_last -> 0, else pc+1.
REQ-027 Jumps: target = imm[14:17] (low AW bits); taken if JMP, or JEZ with ACC==0, JNZ with ACC!=0, JGZ with ACC>0, JLZ with ACC<0 (signed); otherwise pc advances normally.
REQ-028 MOV from port p to port q with p==q is legal: consume, then WAIT_OUT as normal.
REQ-029 run=0 during WAIT_IN/WAIT_OUT does not abort; the instruction completes and the block then goes to IDLE.
REQ-030 prog_we is honoured only in IDLE and is ignored otherwise; program memory is not affected by reset.
REQ-031 At most one bit of in_ready and one bit of out_valid is high at any time.

Reset
REQ-032 On reset: state=IDLE, pc=0, in_ready=0, out_valid=0, busy=0, stall=0, controls = idle set; reset overrides any WAIT state and discards any partial transfer.

Verification
REQ-033 Load MOV IMM(5)->ACC imm=0x07, ADD IMM imm=0x03, run=1 -> ACC=0x0A after 2 cycles, pc=2.
REQ-034 MOV port0->port1 with in_valid[0] held 0 for 5 cycles -> stall=1, in_ready=0, controls idle; in_valid[0]=1 -> in_ready[0]=1 for one cycle, then out_valid[1]=1 until out_ready[1]=1.
REQ-035 ACC=0xFF, JLZ imm=3 -> pc=3; ACC=0x00, JGZ imm=3 -> pc advances by 1; JEZ with ACC=0 is taken.
REQ-036 prog_last=2, three NOPs with run=1 -> pc sequence 0,1,2,0,1.
REQ-037 Reset asserted in WAIT_OUT -> next cycle out_valid=0, pc=0, state IDLE; prog_we during run -> memory unchanged.
